sp_ram_arbiter: RTL and testbench

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

---
 rtl/sp_ram_arb_pkg.sv | 20 ++
 rtl/sp_ram_rr_pick.sv | 28 ++
 rtl/sp_ram_arbiter.sv | 119 +++++++++++
 tb/tb_sp_ram_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_arb_pkg.sv
// Shared types for the single-port RAM arbiter: port index, response record
// and the round-robin pointer advance helper.
package sp_ram_arb_pkg;

   localparam int NUM_PORTS_MAX = 4;

   typedef logic [$clog2(NUM_PORTS_MAX)-1:0] port_idx_t;

   // One outstanding response: which port gets rvalid and whether it carries read data.
   typedef struct packed {
      logic      valid;
      logic      is_read;
      port_idx_t port;
   } resp_t;

   function automatic port_idx_t next_ptr(input port_idx_t k, input int num_ports);
      return (int'(k) == num_ports - 1) ? '0 : port_idx_t'(k + 2'd1);
   endfunction

endpackage

// File: rtl/sp_ram_rr_pick.sv
// Rotating-priority picker: one-hot grant to the first requester at or after ptr.
module sp_ram_rr_pick
   import sp_ram_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [1:0]           ptr,
   output logic [NUM_PORTS-1:0] gnt
);

   always_comb begin : pick
      int   idx;
      logic found;
      // NOTE: every output and temporary gets a default first so no latch is inferred.
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = (int'(ptr) + i) % NUM_PORTS;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_PORTS requesters,
// one access per cycle, with a one-cycle response and read-after-write flag.
module sp_ram_arbiter
   import sp_ram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 18,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_PORTS  = 2
) (
   input  logic                                clk,
   input  logic                                rst_i,
   input  logic [NUM_PORTS-1:0]                req_i,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     addr_i,
   input  logic [NUM_PORTS-1:0]                we_i,
   input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] be_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]     wdata_i,
   output logic [NUM_PORTS-1:0]                gnt_o,
   output logic [NUM_PORTS-1:0]                rvalid_o,
   output logic [DATA_WIDTH-1:0]               rdata_o,
   input  logic                                stall_i,
   output logic                                ram_en_o,
   output logic [ADDR_WIDTH-1:0]               ram_addr_o,
   output logic                                ram_we_o,
   output logic [DATA_WIDTH/8-1:0]             ram_be_o,
   output logic [DATA_WIDTH-1:0]               ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]               ram_rdata_i,
   output logic                                bypass_en_o
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   port_idx_t              rr_ptr;
   resp_t                  resp_q;
   logic                   lw_valid_q;
   logic [ADDR_WIDTH-1:0]  lw_addr_q;

   logic [NUM_PORTS-1:0]   pick_gnt;
   logic                   grant_any;
   logic                   resp_live;
   port_idx_t              win_idx;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic                   sel_we;
   logic [BE_WIDTH-1:0]    sel_be;
   logic [DATA_WIDTH-1:0]  sel_wdata;

   sp_ram_rr_pick #(
      .NUM_PORTS (NUM_PORTS)
   ) u_pick (
      .req (req_i),
      .ptr (rr_ptr),
      .gnt (pick_gnt)
   );

   assign gnt_o     = (rst_i || stall_i) ? '0 : pick_gnt;
   assign grant_any = |gnt_o;

   always_comb begin : winner_mux
      win_idx   = '0;
      sel_addr  = '0;
      sel_we    = 1'b0;
      sel_be    = '0;
      sel_wdata = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (gnt_o[p]) begin
            win_idx   = port_idx_t'(p);
            sel_addr  = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            sel_we    = we_i[p];
            sel_be    = be_i[p*BE_WIDTH +: BE_WIDTH];
            sel_wdata = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign ram_en_o    = grant_any;
   assign ram_addr_o  = sel_addr;
   assign ram_we_o    = sel_we;
   assign ram_be_o    = sel_be;
   assign ram_wdata_o = sel_wdata;

   // A read of the location written by the immediately preceding access.
   assign bypass_en_o = grant_any && !sel_we && lw_valid_q && (sel_addr == lw_addr_q);

   // Reset masks a response still in flight so it never reaches the requester.
   assign resp_live = resp_q.valid && !rst_i;

   always_comb begin : resp_decode
      rvalid_o = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         rvalid_o[p] = resp_live && (resp_q.port == port_idx_t'(p));
      end
   end

   assign rdata_o = (resp_live && resp_q.is_read) ? ram_rdata_i : '0;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         rr_ptr     <= '0;
         resp_q     <= '0;
         lw_valid_q <= 1'b0;
      end else begin
         resp_q.valid   <= grant_any;
         resp_q.is_read <= !sel_we;
         resp_q.port    <= win_idx;
         lw_valid_q     <= grant_any && sel_we;
         if (grant_any) begin
            rr_ptr <= next_ptr(win_idx, NUM_PORTS);
         end
      end
   end

   // NOTE: the address register has no reset; lw_valid_q qualifies it.
   always_ff @(posedge clk) begin
      if (grant_any && sel_we) begin
         lw_addr_q <= sel_addr;
      end
   end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: 2-port and 4-port instances share stimulus and are
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_sp_ram_arbiter;

   localparam int AW = 18;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          stall;
   logic [3:0]    req;
   logic [3:0]    we;
   logic [AW-1:0] addr  [4];
   logic [BW-1:0] be    [4];
   logic [DW-1:0] wdata [4];

   logic [4*AW-1:0] addr_f;
   logic [4*BW-1:0] be_f;
   logic [4*DW-1:0] wdata_f;
   assign addr_f  = {addr[3], addr[2], addr[1], addr[0]};
   assign be_f    = {be[3], be[2], be[1], be[0]};
   assign wdata_f = {wdata[3], wdata[2], wdata[1], wdata[0]};

   logic [1:0]    gnt2, rvalid2;
   logic [DW-1:0] rdata2, rwd2, rrd2;
   logic          en2, we2, byp2;
   logic [AW-1:0] raddr2;
   logic [BW-1:0] rbe2;

   logic [3:0]    gnt4, rvalid4;
   logic [DW-1:0] rdata4, rwd4, rrd4;
   logic          en4, we4, byp4;
   logic [AW-1:0] raddr4;
   logic [BW-1:0] rbe4;

   sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(2)) dut2 (
      .clk(clk), .rst_i(rst),
      .req_i(req[1:0]), .addr_i(addr_f[2*AW-1:0]), .we_i(we[1:0]),
      .be_i(be_f[2*BW-1:0]), .wdata_i(wdata_f[2*DW-1:0]),
      .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2), .stall_i(stall),
      .ram_en_o(en2), .ram_addr_o(raddr2), .ram_we_o(we2), .ram_be_o(rbe2),
      .ram_wdata_o(rwd2), .ram_rdata_i(rrd2), .bypass_en_o(byp2)
   );

   sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(4)) dut4 (
      .clk(clk), .rst_i(rst),
      .req_i(req), .addr_i(addr_f), .we_i(we),
      .be_i(be_f), .wdata_i(wdata_f),
      .gnt_o(gnt4), .rvalid_o(rvalid4), .rdata_o(rdata4), .stall_i(stall),
      .ram_en_o(en4), .ram_addr_o(raddr4), .ram_we_o(we4), .ram_be_o(rbe4),
      .ram_wdata_o(rwd4), .ram_rdata_i(rrd4), .bypass_en_o(byp4)
   );

   // RAM behind each instance: synchronous read, byte-enabled write.
   bit [DW-1:0] ram_a [256];
   bit [DW-1:0] ram_b [256];

   always @(posedge clk) begin
      if (en2) begin
         if (we2) begin
            for (int b = 0; b < BW; b++)
               if (rbe2[b]) ram_a[raddr2[9:2]][8*b +: 8] <= rwd2[8*b +: 8];
         end else begin
            rrd2 <= ram_a[raddr2[9:2]];
         end
      end
   end

   always @(posedge clk) begin
      if (en4) begin
         if (we4) begin
            for (int b = 0; b < BW; b++)
               if (rbe4[b]) ram_b[raddr4[9:2]][8*b +: 8] <= rwd4[8*b +: 8];
         end else begin
            rrd4 <= ram_b[raddr4[9:2]];
         end
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: per instance, pointer, pending response, last write, memory.
   int          m_ptr   [2];
   bit          m_rv    [2];
   bit          m_rread [2];
   int          m_rport [2];
   bit [DW-1:0] m_rdata [2];
   bit          m_lwv   [2];
   bit [AW-1:0] m_lwa   [2];
   bit [DW-1:0] m_mem   [2][256];

   task automatic model_cycle(input int i, input int np,
                              input logic [3:0] a_gnt, input logic [3:0] a_rv,
                              input logic [DW-1:0] a_rd, input logic a_en,
                              input logic [AW-1:0] a_addr, input logic a_we,
                              input logic [BW-1:0] a_be, input logic [DW-1:0] a_wd,
                              input logic a_byp);
      int            win;
      logic [3:0]    e_gnt, e_rv;
      logic [DW-1:0] e_rd, e_wd;
      logic [AW-1:0] e_addr;
      logic [BW-1:0] e_be;
      logic          e_we, e_byp;
      string         pfx;
      pfx = $sformatf("np%0d.", np);

      win = -1;
      if (!rst && !stall) begin
         for (int k = 0; k < np; k++) begin
            int p;
            p = (m_ptr[i] + k) % np;
            if (win < 0 && req[p]) win = p;
         end
      end

      e_gnt = '0; e_rv = '0; e_addr = '0; e_we = 1'b0; e_be = '0; e_wd = '0; e_byp = 1'b0;
      if (win >= 0) begin
         e_gnt[win] = 1'b1;
         e_addr     = addr[win];
         e_we       = we[win];
         e_be       = be[win];
         e_wd       = wdata[win];
         e_byp      = !we[win] && m_lwv[i] && (addr[win] == m_lwa[i]);
      end
      if (m_rv[i] && !rst) e_rv[m_rport[i]] = 1'b1;
      e_rd = (m_rv[i] && m_rread[i] && !rst) ? m_rdata[i] : '0;

      check({pfx, "gnt"},       a_gnt,  e_gnt);
      check({pfx, "rvalid"},    a_rv,   e_rv);
      check({pfx, "rdata"},     a_rd,   e_rd);
      check({pfx, "ram_en"},    a_en,   (win >= 0));
      check({pfx, "ram_addr"},  a_addr, e_addr);
      check({pfx, "ram_we"},    a_we,   e_we);
      check({pfx, "ram_be"},    a_be,   e_be);
      check({pfx, "ram_wdata"}, a_wd,   e_wd);
      check({pfx, "bypass"},    a_byp,  e_byp);

      if (rst) begin
         m_ptr[i] = 0; m_rv[i] = 1'b0; m_rport[i] = 0; m_lwv[i] = 1'b0;
      end else begin
         m_rv[i]  = (win >= 0);
         m_lwv[i] = 1'b0;
         if (win >= 0) begin
            m_rport[i] = win;
            m_rread[i] = !we[win];
            if (we[win]) begin
               for (int b = 0; b < BW; b++)
                  if (be[win][b]) m_mem[i][addr[win][9:2]][8*b +: 8] = wdata[win][8*b +: 8];
               m_lwv[i] = 1'b1;
               m_lwa[i] = addr[win];
            end else begin
               m_rdata[i] = m_mem[i][addr[win][9:2]];
            end
            m_ptr[i] = (win + 1) % np;
         end
      end
   endtask

   always @(negedge clk) begin
      model_cycle(0, 2, {2'b00, gnt2}, {2'b00, rvalid2}, rdata2, en2, raddr2, we2, rbe2, rwd2, byp2);
      model_cycle(1, 4, gnt4, rvalid4, rdata4, en4, raddr4, we4, rbe4, rwd4, byp4);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; req = 4'b1111; we = 4'b0000;
      for (int p = 0; p < 4; p++) begin
         addr[p] = 18'h200 + 18'(4 * p); be[p] = 4'hF; wdata[p] = 32'h0;
      end

      // Reset held with every port requesting.
      for (int c = 0; c < 3; c++) begin
         mid();
         check("rst.gnt2", gnt2, 2'b00);
         check("rst.gnt4", gnt4, 4'b0000);
         check("rst.en2", en2, 1'b0);
         check("rst.rvalid4", rvalid4, 4'b0000);
         cyc();
      end

      // Contention between ports 0 and 1 straight out of reset.
      rst = 1'b0; req = 4'b0011;
      for (int c = 0; c < 8; c++) begin
         mid();
         check("cont.gnt2", gnt2, (c % 2 == 0) ? 2'b01 : 2'b10);
         check("cont.gnt4", gnt4, (c % 2 == 0) ? 4'b0001 : 4'b0010);
         check("cont.rvalid2", rvalid2, (c == 0) ? 2'b00 : ((c % 2 == 1) ? 2'b01 : 2'b10));
         cyc();
      end

      // Read-after-write through the RAM with the bypass flag.
      req = 4'b0001; we[0] = 1'b1; addr[0] = 18'h100; be[0] = 4'hF; wdata[0] = 32'hDEADBEEF;
      mid(); check("raw.wgnt2", gnt2, 2'b01); check("raw.we2", we2, 1'b1); cyc();
      req = 4'b0010; we[0] = 1'b0; we[1] = 1'b0; addr[1] = 18'h100;
      mid(); check("raw.rgnt2", gnt2, 2'b10); check("raw.byp2", byp2, 1'b1); check("raw.byp4", byp4, 1'b1); cyc();
      req = 4'b0000;
      mid();
      check("raw.rvalid2", rvalid2, 2'b10);
      check("raw.rdata2", rdata2, 32'hDEADBEEF);
      check("raw.rdata4", rdata4, 32'hDEADBEEF);
      cyc();
      req = 4'b0010;
      mid(); check("raw.nobyp2", byp2, 1'b0); cyc();
      req = 4'b0001;
      mid(); check("pre_stall.gnt2", gnt2, 2'b01); cyc();

      // Stall: no grants, pointer frozen at port 1.
      req = 4'b0011; stall = 1'b1;
      for (int c = 0; c < 4; c++) begin
         mid();
         check("stall.gnt2", gnt2, 2'b00);
         check("stall.gnt4", gnt4, 4'b0000);
         check("stall.en2", en2, 1'b0);
         cyc();
      end
      stall = 1'b0;
      mid(); check("unstall.gnt2", gnt2, 2'b10); check("unstall.gnt4", gnt4, 4'b0010); cyc();

      // Reset arriving the cycle after a read grant.
      req = 4'b0001; we[0] = 1'b0;
      mid(); check("rstmid.gnt2", gnt2, 2'b01); cyc();
      rst = 1'b1; req = 4'b0000;
      mid(); check("rstmid.rv2_n1", rvalid2, 2'b00); check("rstmid.rv4_n1", rvalid4, 4'b0000); cyc();
      rst = 1'b0;
      mid(); check("rstmid.rv2_n2", rvalid2, 2'b00); check("rstmid.rv4_n2", rvalid4, 4'b0000); cyc();

      // Single continuous requester on port 3.
      req = 4'b1000;
      for (int c = 0; c < 6; c++) begin
         mid();
         check("p3.gnt4", gnt4, 4'b1000);
         check("p3.gnt2", gnt2, 2'b00);
         if (c > 0) check("p3.rvalid4", rvalid4, 4'b1000);
         cyc();
      end

      // Randomized traffic, checked by the model process.
      for (int c = 0; c < 1500; c++) begin
         rst   = ($urandom % 100) == 0;
         stall = ($urandom % 8) == 0;
         req   = 4'($urandom);
         for (int p = 0; p < 4; p++) begin
            we[p]    = $urandom % 2;
            addr[p]  = (($urandom % 4) != 0) ? 18'h100 + 18'(4 * ($urandom % 2))
                                              : 18'(($urandom % 256) * 4);
            be[p]    = 4'($urandom);
            wdata[p] = $urandom;
         end
         cyc();
      end

      rst = 1'b0; stall = 1'b0; req = 4'b0000;
      cyc(); cyc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
